// File: rtl/env_adsr.sv
// ADSR envelope generator: a 2*WIDTH-bit level accumulator stepped on the
// sample-rate tick, with the upper WIDTH bits driven out as the VCA control voltage.
module env_adsr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             gate,
    input  logic [WIDTH-1:0] attack,
    input  logic [WIDTH-1:0] decay,
    input  logic [WIDTH-1:0] sustain,
    // "release" is a reserved word, so the release rate is carried on rel.
    input  logic [WIDTH-1:0] rel,
    output logic [WIDTH-1:0] cv,
    output logic [2:0]       state,
    output logic             busy,
    output logic             done
);
    localparam int LW = 2 * WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    adsr_state_t     state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic            gate_prev_q, gate_prev_d;
    logic            done_q, done_d;

    // Steps are 1..2^WIDTH; every compare is done one bit wider than the level.
    logic [WIDTH:0]  step_a, step_d, step_r;
    logic [LW:0]     ext_a, ext_d, ext_r, lvl_ext, sus_ext, att_sum;

    assign step_a  = {1'b1, {WIDTH{1'b0}}} - {1'b0, attack};
    assign step_d  = {1'b1, {WIDTH{1'b0}}} - {1'b0, decay};
    assign step_r  = {1'b1, {WIDTH{1'b0}}} - {1'b0, rel};
    assign ext_a   = {{(LW-WIDTH){1'b0}}, step_a};
    assign ext_d   = {{(LW-WIDTH){1'b0}}, step_d};
    assign ext_r   = {{(LW-WIDTH){1'b0}}, step_r};
    assign lvl_ext = {1'b0, level_q};
    assign sus_ext = {1'b0, sustain, {WIDTH{1'b0}}};
    assign att_sum = lvl_ext + ext_a;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            gate_prev_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            gate_prev_q <= gate_prev_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        gate_prev_d = gate_prev_q;
        done_d      = 1'b0;
        if (tick) begin
            gate_prev_d = gate;
            if (gate && !gate_prev_q) begin
                state_d = ST_ATTACK;
            end else if (!gate && gate_prev_q &&
                         (state_q == ST_ATTACK || state_q == ST_DECAY ||
                          state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end else begin
                unique case (state_q)
                    ST_IDLE: level_d = '0;
                    ST_ATTACK: begin
                        if (att_sum >= {1'b0, {LW{1'b1}}}) begin
                            level_d = {LW{1'b1}};
                            state_d = ST_DECAY;
                        end else begin
                            level_d = att_sum[LW-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if (lvl_ext <= sus_ext + ext_d) begin
                            level_d = sus_ext[LW-1:0];
                            state_d = ST_SUSTAIN;
                        end else begin
                            level_d = level_q - ext_d[LW-1:0];
                        end
                    end
                    ST_SUSTAIN: level_d = sus_ext[LW-1:0];
                    ST_RELEASE: begin
                        if (lvl_ext <= ext_r) begin
                            level_d = '0;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            level_d = level_q - ext_r[LW-1:0];
                        end
                    end
                    default: begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cv    = level_q[LW-1:WIDTH];
    assign state = state_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
endmodule

// File: tb/tb_env_adsr.sv
// Bench for env_adsr: directed scenarios plus a randomized run, all checked
// against an integer model of the envelope rules.
module tb_env_adsr;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       gate = 1'b0;
    logic [7:0] attack = 8'd0, decay = 8'd0, sustain = 8'd0, rel = 8'd0;
    logic [7:0] cv;
    logic [2:0] state;
    logic       busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integers, states 0..4 as numbered in the interface.
    int ml = 0, ms = 0;
    bit mprev = 1'b0, mdone = 1'b0;

    env_adsr #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .gate(gate),
        .attack(attack), .decay(decay), .sustain(sustain), .rel(rel),
        .cv(cv), .state(state), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        ml = 0; ms = 0; mprev = 1'b0; mdone = 1'b0;
    endtask

    task automatic model_tick(input bit g);
        int sa, sd, sr, s;
        sa = 256 - int'(attack);
        sd = 256 - int'(decay);
        sr = 256 - int'(rel);
        s  = int'(sustain) * 256;
        mdone = 1'b0;
        if (g && !mprev) ms = 1;
        else if (!g && mprev && ms >= 1 && ms <= 3) ms = 4;
        else begin
            case (ms)
                0: ml = 0;
                1: if (ml + sa >= 65535) begin ml = 65535; ms = 2; end else ml = ml + sa;
                2: if (ml <= s + sd) begin ml = s; ms = 3; end else ml = ml - sd;
                3: ml = s;
                4: if (ml <= sr) begin ml = 0; ms = 0; mdone = 1'b1; end else ml = ml - sr;
                default: ms = 0;
            endcase
        end
        mprev = g;
    endtask

    // One tick cycle; outputs are then sampled on the following falling edge.
    task automatic tick_once(input logic g);
        @(negedge clk);
        gate = g;
        tick = 1'b1;
        model_tick(g);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        int seen_done = 0, bad_state = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (cv !== 8'd0 || state !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: cv=%0d state=%0d busy=%0b done=%0b, required 0/0/0/0",
                     cv, state, busy, done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); tick = 1'b1; model_tick(1'b0);
            @(negedge clk); tick = 1'b0;
            if (done === 1'b1) seen_done++;
            if (state !== 3'd0 || cv !== 8'd0 || busy !== 1'b0) bad_state++;
            repeat (2) @(negedge clk);
        end
        n_tests++;
        if (seen_done != 0 || bad_state != 0) begin
            n_fail++;
            $display("FAIL idle_ticks: done pulses=%0d bad samples=%0d, required 0/0",
                     seen_done, bad_state);
        end
    endtask

    task automatic test_attack();
        int wrap = 0;
        logic [7:0] last;
        attack = 8'd0;
        tick_once(1'b1);
        n_tests++;
        if (state !== 3'd1 || cv !== 8'd0) begin
            n_fail++;
            $display("FAIL attack_entry: state=%0d cv=%0d, required 1/0", state, cv);
        end
        tick_once(1'b1);
        n_tests++;
        if (cv !== 8'd1) begin
            n_fail++;
            $display("FAIL attack_first_step: cv=%0d, required 1", cv);
        end
        last = cv;
        for (int i = 2; i <= 255; i++) begin
            tick_once(1'b1);
            if (cv < last) wrap++;
            last = cv;
        end
        n_tests++;
        if (state !== 3'd1 || cv !== 8'd255 || wrap != 0) begin
            n_fail++;
            $display("FAIL attack_tick255: state=%0d cv=%0d wraps=%0d, required 1/255/0",
                     state, cv, wrap);
        end
        tick_once(1'b1);
        n_tests++;
        if (state !== 3'd2 || cv !== 8'd255) begin
            n_fail++;
            $display("FAIL attack_saturate: state=%0d cv=%0d, required 2/255", state, cv);
        end
    endtask

    task automatic test_decay();
        int n = 0;
        decay = 8'd0; sustain = 8'd128;
        while (state != 3'd3 && n < 300) begin
            tick_once(1'b1);
            n++;
        end
        n_tests++;
        if (state !== 3'd3 || cv !== 8'd128 || 8'(ml >> 8) !== 8'd128 || ms != 3) begin
            n_fail++;
            $display("FAIL decay_to_sustain: state=%0d cv=%0d after %0d ticks, required 3/128",
                     state, cv, n);
        end
        sustain = 8'd64;
        tick_once(1'b1);
        n_tests++;
        if (cv !== 8'd64 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL sustain_track: cv=%0d state=%0d, required 64/3", cv, state);
        end
    endtask

    task automatic test_release();
        sustain = 8'd255; rel = 8'd0;
        tick_once(1'b1);
        n_tests++;
        if (cv !== 8'd255 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL sustain_max: cv=%0d state=%0d, required 255/3", cv, state);
        end
        tick_once(1'b0);
        n_tests++;
        if (state !== 3'd4 || cv !== 8'd255) begin
            n_fail++;
            $display("FAIL release_entry: state=%0d cv=%0d, required 4/255", state, cv);
        end
        for (int i = 1; i <= 254; i++) tick_once(1'b0);
        n_tests++;
        if (state !== 3'd4 || cv !== 8'd1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL release_tick254: state=%0d cv=%0d done=%0b, required 4/1/0",
                     state, cv, done);
        end
        tick_once(1'b0);
        n_tests++;
        if (state !== 3'd0 || cv !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_end: state=%0d cv=%0d done=%0b busy=%0b, required 0/0/1/0",
                     state, cv, done, busy);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%0b one cycle later, required 0", done);
        end
    endtask

    task automatic test_legato();
        int n = 0;
        attack = 8'd0; decay = 8'd0; sustain = 8'd200; rel = 8'd0;
        while (state != 3'd3 && n < 600) begin
            tick_once(1'b1);
            n++;
        end
        tick_once(1'b0);
        for (int i = 0; i < 100; i++) tick_once(1'b0);
        n_tests++;
        if (state !== 3'd4 || cv !== 8'd100) begin
            n_fail++;
            $display("FAIL legato_setup: state=%0d cv=%0d, required 4/100", state, cv);
        end
        tick_once(1'b1);
        n_tests++;
        if (state !== 3'd1 || cv !== 8'd100) begin
            n_fail++;
            $display("FAIL legato_retrigger: state=%0d cv=%0d, required 1/100", state, cv);
        end
        tick_once(1'b1);
        n_tests++;
        if (cv !== 8'd101) begin
            n_fail++;
            $display("FAIL legato_continue: cv=%0d, required 101", cv);
        end
        n = 0;
        while (cv != 8'd255 && n < 300) begin
            tick_once(1'b1);
            n++;
        end
        // Next step would saturate; the falling gate on that same tick must win.
        tick_once(1'b0);
        n_tests++;
        if (state !== 3'd4 || cv !== 8'd255 || ms != 4) begin
            n_fail++;
            $display("FAIL fall_beats_saturate: state=%0d cv=%0d, required 4/255", state, cv);
        end
        n = 0;
        while (state != 3'd0 && n < 300) begin
            tick_once(1'b0);
            n++;
        end
    endtask

    task automatic test_sustain_zero();
        int n = 0;
        attack = 8'd0; decay = 8'd0; sustain = 8'd0;
        while (ms != 3 && n < 600) begin
            tick_once(1'b1);
            n++;
        end
        repeat (3) tick_once(1'b1);
        n_tests++;
        if (state !== 3'd3 || cv !== 8'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sustain_zero_hold: state=%0d cv=%0d busy=%0b, required 3/0/1",
                     state, cv, busy);
        end
        tick_once(1'b0);
        tick_once(1'b0);
        n_tests++;
        if (state !== 3'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL sustain_zero_release: state=%0d done=%0b, required 0/1", state, done);
        end
    endtask

    task automatic test_random();
        int errs = 0, gap;
        logic g = 1'b0;
        for (int i = 0; i < 600; i++) begin
            attack  = 8'($urandom_range(150, 255));
            decay   = 8'($urandom_range(150, 255));
            sustain = 8'($urandom);
            rel     = 8'($urandom_range(150, 255));
            if ($urandom_range(0, 39) == 0) g = ~g;
            tick_once(g);
            if (cv !== 8'(ml >> 8) || state !== 3'(ms) || busy !== (ms != 0) || done !== mdone)
                errs++;
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                // A short gate glitch that never overlaps a tick must be ignored.
                if ($urandom_range(0, 3) == 0) gate = ~g;
                @(negedge clk);
                gate = g;
                if (done !== 1'b0 || cv !== 8'(ml >> 8)) errs++;
            end
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL random_vs_model: %0d sample mismatches, required 0", errs);
        end
    endtask

    task automatic test_async_reset();
        attack = 8'd250;
        tick_once(1'b0);
        tick_once(1'b1);
        for (int i = 0; i < 40; i++) tick_once(1'b1);
        n_tests++;
        if (state !== 3'd1 || cv === 8'd0) begin
            n_fail++;
            $display("FAIL async_setup: state=%0d cv=%0d, required 1/nonzero", state, cv);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cv !== 8'd0 || state !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cv=%0d state=%0d busy=%0b, required 0/0/0",
                     cv, state, busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        gate = 1'b1;
        tick_once(1'b1);
        n_tests++;
        if (state !== 3'd1 || cv !== 8'd0) begin
            n_fail++;
            $display("FAIL gate_high_after_reset: state=%0d cv=%0d, required 1/0", state, cv);
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_legato();
        test_sustain_zero();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
